// File: rtl/top_level_if.sv
// Data-memory port bundle between the processor core and its 256x8 data store.
interface dm_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/top_level.sv
// Single-cycle 8-bit accumulator processor: 1024x9 ROM, 256x8 data memory, 8x8 register file.
// ROM and DM contents are loaded from outside through the IR/DM instance arrays.
module instr_rom (
  input  logic [9:0] addr,
  output logic [8:0] inst
);
  logic [8:0] inst_rom [0:1023];
  assign inst = inst_rom[addr];
endmodule

module data_mem (
  input logic clk,
  dm_if.slave bus
);
  logic [7:0] Core [0:255];

  // No reset: preloaded data must survive a reset.
  assign bus.rdata = Core[bus.addr];
  always_ff @(posedge clk)
    if (bus.we) Core[bus.addr] <= bus.wdata;
endmodule

module top_level (
  input  logic clk,
  input  logic rst,
  output logic done
);
  logic [9:0]      pc, pc_nxt;
  logic [8:0]      inst;
  logic [7:0][7:0] regs;
  logic            z_flag, c_flag, z_nxt, c_nxt;
  logic [3:0]      op;
  logic [1:0]      sub;
  logic [2:0]      ra;
  logic [7:0]      r0, rv, r0_nxt, diff;
  logic [9:0]      off5, off8;
  logic            r0_we, rr_we, halt, st;

  dm_if dm_bus ();

  instr_rom IR (.addr(pc), .inst(inst));
  data_mem  DM (.clk(clk), .bus(dm_bus));

  assign op   = inst[8:5];
  assign sub  = inst[4:3];
  assign ra   = inst[2:0];
  assign r0   = regs[0];
  assign rv   = regs[ra];
  assign diff = r0 - rv;
  assign off5 = {{5{inst[4]}}, inst[4:0]};
  assign off8 = {{2{rv[7]}}, rv};

  assign dm_bus.addr  = rv;
  assign dm_bus.wdata = r0;
  assign dm_bus.we    = st & ~done;

  always_comb begin
    pc_nxt = pc + 10'd1;
    r0_nxt = r0;
    r0_we  = 1'b1;
    rr_we  = 1'b0;
    z_nxt  = z_flag;
    c_nxt  = c_flag;
    halt   = 1'b0;
    st     = 1'b0;
    case (op)
      4'h0: r0_nxt = {3'b000, inst[4:0]};
      4'h1: r0_nxt = {inst[2:0], r0[4:0]};
      4'h2: begin r0_we = 1'b0; rr_we = 1'b1; end
      4'h3: r0_nxt = rv;
      4'h4: r0_nxt = r0 + rv;
      4'h5: begin
        r0_nxt = diff;
        z_nxt  = (diff == 8'd0);
        c_nxt  = (r0 < rv);
      end
      4'h6: r0_nxt = r0 & rv;
      4'h7: r0_nxt = r0 ^ rv;
      4'h8: begin
        case (sub)
          2'b00:   r0_nxt = {r0[6:0], 1'b0};
          2'b01:   r0_nxt = {1'b0, r0[7:1]};
          2'b10:   r0_nxt = r0 | rv;
          default: r0_nxt = ~r0;
        endcase
      end
      4'h9: r0_nxt = {7'd0, ^rv};
      4'hA: r0_nxt = dm_bus.rdata;
      4'hB: begin r0_we = 1'b0; st = 1'b1; end
      4'hC: begin
        r0_we = 1'b0;
        z_nxt = (r0 == rv);
        c_nxt = (r0 < rv);
      end
      4'hD: begin r0_we = 1'b0; if (z_flag)  pc_nxt = pc + off5; end
      4'hE: begin r0_we = 1'b0; if (!z_flag) pc_nxt = pc + off5; end
      default: begin
        r0_we = 1'b0;
        case (sub)
          2'b00: begin halt = 1'b1; pc_nxt = pc; end
          2'b01: pc_nxt = pc + off8;
          default: ;
        endcase
      end
    endcase
  end

  // Once done is set every piece of architectural state holds until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      regs   <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      done   <= 1'b0;
    end else if (!done) begin
      pc     <= pc_nxt;
      z_flag <= z_nxt;
      c_flag <= c_nxt;
      done   <= halt;
      if (r0_we) regs[0]  <= r0_nxt;
      if (rr_we) regs[ra] <= r0;
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Directed and random program runs against an instruction-set interpreter model.
module tb_top_level;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done;

  top_level dut (.clk(clk), .rst(rst), .done(done));

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic [8:0] m_rom [0:1023];
  int m_dm [0:255];
  int m_r [0:7];
  int m_pc, m_z, m_c, m_done;
  logic [8:0] prog [$];

  function automatic logic [8:0] ins(input int op, input int opd);
    return 9'((op << 5) | (opd & 31));
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-set interpreter: one architectural step per call.
  task automatic m_step();
    logic [8:0] w;
    int op, r, a, v, nxt, off;
    if (m_done != 0) return;
    w = m_rom[m_pc];
    op = int'(w[8:5]);
    r = int'(w[2:0]);
    a = m_r[0];
    v = m_r[r];
    nxt = (m_pc + 1) % 1024;
    off = w[4] ? int'(w[4:0]) - 32 : int'(w[4:0]);
    case (op)
      0: m_r[0] = int'(w[4:0]);
      1: m_r[0] = int'(w[2:0]) * 32 + a % 32;
      2: m_r[r] = a;
      3: m_r[0] = v;
      4: m_r[0] = (a + v) % 256;
      5: begin m_r[0] = (a - v + 256) % 256; m_z = (a == v); m_c = (a < v); end
      6: m_r[0] = a & v;
      7: m_r[0] = a ^ v;
      8: case (int'(w[4:3]))
           0: m_r[0] = (a * 2) % 256;
           1: m_r[0] = a / 2;
           2: m_r[0] = a | v;
           default: m_r[0] = 255 - a;
         endcase
      9: m_r[0] = $countones(v) % 2;
      10: m_r[0] = m_dm[v];
      11: m_dm[v] = a;
      12: begin m_z = (a == v); m_c = (a < v); end
      13: if (m_z != 0) nxt = (m_pc + off + 1024) % 1024;
      14: if (m_z == 0) nxt = (m_pc + off + 1024) % 1024;
      default: case (int'(w[4:3]))
           0: begin m_done = 1; nxt = m_pc; end
           1: nxt = (m_pc + (v >= 128 ? v - 256 : v) + 1024) % 1024;
           default: ;
         endcase
    endcase
    m_pc = nxt;
  endtask

  task automatic m_reset();
    m_pc = 0; m_z = 0; m_c = 0; m_done = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_pc"}, 16'(dut.pc), 16'd0);
    check({tag, "_done"}, 16'(done), 16'd0);
    check({tag, "_zc"}, 16'({dut.z_flag, dut.c_flag}), 16'd0);
    for (int i = 0; i < 8; i++) check({tag, "_reg"}, 16'(dut.regs[i]), 16'd0);
  endtask

  // Reset, load prog[] into ROM (NOP fill) and release reset at a falling edge.
  task automatic begin_prog();
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_done_drop", 16'(done), 16'd0);
    m_reset();
    for (int i = 0; i < 1024; i++) begin
      m_rom[i] = (i < prog.size()) ? prog[i] : ins(15, 16);
      dut.IR.inst_rom[i] = m_rom[i];
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      m_step();
      #1;
      check("pc_step", 16'(dut.pc), 16'(m_pc));
      check("done_step", 16'(done), 16'(m_done));
    end
  endtask

  task automatic cmp_state(input bit with_dm);
    for (int i = 0; i < 8; i++) check("reg_model", 16'(dut.regs[i]), 16'(m_r[i]));
    check("z_model", 16'(dut.z_flag), 16'(m_z));
    check("c_model", 16'(dut.c_flag), 16'(m_c));
    if (with_dm)
      for (int i = 0; i < 256; i++) check("dm_model", 16'(dut.DM.Core[i]), 16'(m_dm[i]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_dm[i] = 0;
      dut.DM.Core[i] = 8'h00;
    end

    // Constant/store: done on the 6th edge.
    prog = '{ins(0, 10), ins(2, 1), ins(0, 5), ins(1, 3), ins(11, 1), ins(15, 0)};
    begin_prog();
    chk_reset("reset_a");
    run(5);
    check("const_done_early", 16'(done), 16'd0);
    run(1);
    check("const_done", 16'(done), 16'd1);
    check("const_r0", 16'(dut.regs[0]), 16'h65);
    check("const_r1", 16'(dut.regs[1]), 16'h0A);
    check("const_dm10", 16'(dut.DM.Core[10]), 16'h65);
    run(3);
    check("const_frozen_pc", 16'(dut.pc), 16'd5);
    cmp_state(1'b1);

    // Reset asserted while a loop runs.
    prog = '{ins(0, 3), ins(2, 1), ins(4, 1), ins(14, 5'h1F)};
    begin_prog();
    run(10);
    #2 rst = 1'b0;
    #1 chk_reset("reset_async");
    repeat (2) @(negedge clk);
    chk_reset("reset_hold");
    check("reset_dm_kept", 16'(dut.DM.Core[10]), 16'h65);

    // Load / parity / XOR.
    @(negedge clk);
    dut.DM.Core[64] = 8'hC3;
    m_dm[64] = 8'hC3;
    prog = '{ins(0, 0), ins(1, 2), ins(2, 2), ins(0, 5'h1A), ins(1, 2), ins(2, 3),
             ins(10, 2), ins(9, 0), ins(7, 3), ins(15, 0)};
    begin_prog();
    run(7);
    check("ld_r0", 16'(dut.regs[0]), 16'hC3);
    run(1);
    check("par_r0", 16'(dut.regs[0]), 16'h00);
    run(1);
    check("xor_r0", 16'(dut.regs[0]), 16'h5A);
    run(1);
    check("par_done", 16'(done), 16'd1);
    cmp_state(1'b0);

    // Counting loop: 6 setup + 3x4 body + HALT = 19 edges.
    prog = '{ins(0, 1), ins(2, 2), ins(0, 3), ins(2, 3), ins(0, 0), ins(2, 1),
             ins(4, 2), ins(2, 1), ins(12, 3), ins(14, 5'h1D), ins(15, 0)};
    begin_prog();
    run(18);
    check("loop_done_early", 16'(done), 16'd0);
    run(1);
    check("loop_done", 16'(done), 16'd1);
    check("loop_r1", 16'(dut.regs[1]), 16'd3);
    check("loop_z", 16'(dut.z_flag), 16'd1);

    // Rerun a new image; DM from earlier runs is retained.
    prog = '{ins(0, 10), ins(2, 1), ins(10, 1), ins(2, 4), ins(15, 0)};
    begin_prog();
    run(5);
    check("rerun_r4", 16'(dut.regs[4]), 16'h65);
    check("rerun_done", 16'(done), 16'd1);
    check("rerun_dm64", 16'(dut.DM.Core[64]), 16'hC3);

    // PC wrap: BNZ -1 at 0 goes to 1023, NOP there wraps to 0.
    prog = '{ins(14, 5'h1F)};
    begin_prog();
    run(1);
    check("wrap_back", 16'(dut.pc), 16'd1023);
    run(1);
    check("wrap_fwd", 16'(dut.pc), 16'd0);

    // JR with Rr = 0xFE at PC 5 lands on 3.
    prog = '{ins(0, 5'h1E), ins(1, 7), ins(2, 5), ins(15, 16), ins(15, 16), ins(15, 13)};
    begin_prog();
    run(6);
    check("jr_pc", 16'(dut.pc), 16'd3);
    check("jr_r5", 16'(dut.regs[5]), 16'hFE);

    // Random programs and data against the interpreter.
    for (int round = 0; round < 4; round++) begin
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
        m_dm[i] = int'($urandom_range(0, 255));
        dut.DM.Core[i] = 8'(m_dm[i]);
      end
      prog = {};
      for (int i = 0; i < 64; i++) prog.push_back(9'($urandom_range(0, 511)));
      begin_prog();
      run(150);
      cmp_state(1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
